fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Round-robin write-port arbiter that shares the write side of the asynchronous FIFO among several producers in the write clock domain. Each producer presents a valid/ready stream; the arbiter grants one producer at a time for a bounded burst, drives the FIFO `w_en` and data inputs, and honours the FIFO `full` flag so that no word is dropped or duplicated. It sits directly in front of the FIFO write port and runs entirely on `wclk`.

## Interface
- `NUM_REQ`, default 4: number of producers; 2..8.
- `DATA_WIDTH`, default 8: word width, equal to the FIFO `DATA_WIDTH`.
- `BURST_LEN`, default 4: maximum accepted words per grant; 1..16.
- `wclk  in  1`: write-domain clock.
- `wrst_n  in  1`: reset. One clock; reset is asynchronous and active-low.
- `req_valid  in  NUM_REQ`: per-producer word valid.
- `req_data  in  NUM_REQ*DATA_WIDTH`: per-producer word; producer i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready  out  NUM_REQ`: per-producer accept; at most one bit high.
- `grant  out  NUM_REQ`: one-hot current owner; all-zero in IDLE.
- `full  in  1`: FIFO full flag (write domain).
- `half_full  in  1`: FIFO half-full flag (write domain).
- `w_en  out  1`: FIFO write enable.
- `wdata  out  DATA_WIDTH`: FIFO write data.

## Operation
- FSM states: IDLE, GRANT. Registers: `state`, `owner` (log2 NUM_REQ bits), `last_owner`, `burst_cnt` (log2(BURST_LEN)+1 bits).
- IDLE: scan `req_valid` starting at `last_owner+1`, wrapping modulo NUM_REQ; first set bit becomes `owner`; go to GRANT next edge, `burst_cnt` <= 0. No request: stay IDLE.
- GRANT: `grant[owner]`=1. `req_ready[owner]` = !full. `w_en` = req_valid[owner] & !full. `wdata` = req_data slice of `owner` whenever in GRANT; 0 in IDLE.
- Transfer = `w_en` high at a rising edge. Each transfer increments `burst_cnt`.
- Exit GRANT to IDLE, `last_owner` <= `owner`, when: transfer occurs and `burst_cnt` == limit-1; or `req_valid[owner]` low at an edge (producer released grant).
- `full` high: no transfer, `burst_cnt` holds, grant held; stall is not counted and has no timeout.
- Burst limit = BURST_LEN (see Configuration for throttle).
- Requests from non-owners are ignored until return to IDLE; no data path from non-owners.
- Arbitration is work-conserving only at IDLE; one IDLE cycle separates consecutive grants.

## Timing
- Reset (async assert): state=IDLE, `last_owner`=NUM_REQ-1 (producer 0 wins first), `burst_cnt`=0, `grant`=0, `req_ready`=0, `w_en`=0, `wdata`=0. Reset mid-burst drops grant immediately; any word not yet clocked is not written.
- Request latency: `req_valid` high in IDLE at edge n → `grant` and first possible `w_en` in cycle after edge n.
- `w_en`, `req_ready`, `wdata` are combinational from `state`/`owner`/`req_valid`/`full`/`req_data`; grant and state are registered.
- Steady state with no `full`: BURST_LEN words per BURST_LEN+1 cycles.
- `full` sampled same cycle as `w_en`; FIFO's registered `full` is conservative, so no overflow.
- Wrap-around: owner NUM_REQ-1 followed by owner 0 when both request.

## Configuration
- Macro `FIFO_ARB_HF_THROTTLE_EN`.
- Defined: while `half_full` is high at the edge a grant is issued, burst limit for that grant is 1; otherwise BURST_LEN. Limit is latched at grant and not changed mid-burst.
- Undefined: `half_full` ignored; limit always BURST_LEN.

## Test plan
- Reset then req_valid=4'b0001, 6 words, full=0 → grant=0001 next cycle, 4 writes back-to-back, 1 IDLE cycle, grant=0001 again, 2 writes, release on valid low.
- All four producers valid continuously → grant order 0,1,2,3,0; each holds 4 transfers; w_en duty 4/5.
- Owner 2 granted, full forced high for 3 cycles after word 2 → w_en=0, req_ready=0 for 3 cycles, burst_cnt holds, exactly 4 words written total with correct data order.
- Owner 1 drops req_valid after 2 words → grant released, next IDLE selects producer 2 if valid, FIFO holds exactly 2 words from producer 1.
- With FIFO_ARB_HF_THROTTLE_EN and half_full=1, all producers valid → one word per grant, rotation 0,1,2,3; without macro → 4 words per grant.
- wrst_n pulsed low mid-burst (owner 3, word 2) → grant/w_en/req_ready drop asynchronously to 0; after release, producer 0 wins first.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
// fifo_wr_arbiter : round-robin burst arbiter for the async FIFO write port.
// Optional macro FIFO_ARB_HF_THROTTLE_EN: one-word grants while half_full.
// Revision 1.0
// ============================================================================
`default_nettype none

module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                          wclk,
    input  logic                          wrst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            grant,
    input  logic                          full,
    input  logic                          half_full,
    output logic                          w_en,
    output logic [DATA_WIDTH-1:0]         wdata
);

    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(BURST_LEN) + 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    localparam logic [OW-1:0] LAST_INIT = OW'(NUM_REQ - 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

    logic [0:0]            state;
    logic [OW-1:0]         owner;
    logic [OW-1:0]         last_owner;
    logic [CW-1:0]         burst_cnt;

    logic [OW-1:0]         next_owner;
    logic [OW:0]           cand;
    logic                  found;
    logic                  owner_valid;
    logic [DATA_WIDTH-1:0] own_data;
    logic [NUM_REQ-1:0]    own_onehot;
    logic                  in_grant;
    logic                  last_beat;

    // Round-robin search starting just after the previous owner.
    always_comb begin
        found      = 1'b0;
        next_owner = last_owner;
        cand       = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = {1'b0, last_owner} + (OW+1)'(i);
            if (cand >= (OW+1)'(NUM_REQ)) begin
                cand = cand - (OW+1)'(NUM_REQ);
            end
            if (!found && req_valid[cand[OW-1:0]]) begin
                found      = 1'b1;
                next_owner = cand[OW-1:0];
            end
        end
    end

    always_comb begin
        owner_valid = 1'b0;
        own_data    = '0;
        own_onehot  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == OW'(i)) begin
                owner_valid   = req_valid[i];
                own_data      = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                own_onehot[i] = 1'b1;
            end
        end
    end

    assign in_grant  = (state == GRANT);
    assign grant     = in_grant ? own_onehot : '0;
    assign req_ready = (in_grant && !full) ? own_onehot : '0;
    assign w_en      = in_grant & owner_valid & ~full;
    assign wdata     = in_grant ? own_data : '0;

`ifdef FIFO_ARB_HF_THROTTLE_EN
    logic limit_one;

    // Limit is captured when the grant is issued and held for the whole burst.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            limit_one <= 1'b0;
        end else if (state == IDLE && found) begin
            limit_one <= half_full;
        end
    end

    assign last_beat = limit_one || (burst_cnt == LAST_BEAT);
`else
    logic unused_half_full;
    assign unused_half_full = half_full;
    assign last_beat        = (burst_cnt == LAST_BEAT);
`endif

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= LAST_INIT;
            burst_cnt  <= '0;
        end else if (state == IDLE) begin
            if (found) begin
                state     <= GRANT;
                owner     <= next_owner;
                burst_cnt <= '0;
            end
        end else begin
            if (!owner_valid) begin
                state      <= IDLE;
                last_owner <= owner;
            end else if (!full) begin
                burst_cnt <= burst_cnt + CW'(1);
                if (last_beat) begin
                    state      <= IDLE;
                    last_owner <= owner;
                end
            end
        end
    end

endmodule

`default_nettype wire
